// File: rtl/watch_pkg.sv
// watch_pkg: shared types and BCD helpers for the multi-mode watch.
// Used by watch_multimode and key_press_detect.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_WATCH     = 2'd0,
    MODE_SET_HH    = 2'd1,
    MODE_SET_MM    = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  typedef enum logic {
    VIEW_HHMM = 1'b0,
    VIEW_MMSS = 1'b1
  } view_e;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // two-digit BCD increment, 59 wraps to 00
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // hour increment: 23->00 in 24 h, 12->01 in 12 h
  function automatic logic [7:0] bcd_inc_hour(
    input logic [7:0] v,
    input logic       h24
  );
    logic [7:0] r;
    if (h24 && v == 8'h23)
      r = 8'h00;
    else if (!h24 && v == 8'h12)
      r = 8'h01;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: sync, debounce and short/long press classification.
// Pulses are one cycle; a long press suppresses the short on release.
module key_press_detect
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic short_p,
  output logic long_p
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          ldone_q, ldone_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // debounce the synchronised level and classify the hold
  always_comb begin
    deb_d   = deb_q;
    dcnt_d  = '0;
    hold_d  = hold_q;
    ldone_d = ldone_q;
    long_d  = 1'b0;
    if (!sync2_q != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYC - 1))
        deb_d = ~deb_q;
      else
        dcnt_d = dcnt_q + 1'b1;
    end
    if (deb_q) begin
      if (!ldone_q) begin
        if (hold_q == LW'(LONG_CYC - 1)) begin
          long_d  = 1'b1;
          ldone_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end else begin
      hold_d  = '0;
      ldone_d = 1'b0;
    end
    short_d = deb_q & ~deb_d & ~ldone_q & ~long_d;
  end

  // detector registers; idle level is released
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      hold_q  <= '0;
      ldone_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      hold_q  <= hold_d;
      ldone_q <= ldone_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign pressed = deb_q;
  assign short_p = short_q;
  assign long_p  = long_q;

endmodule

// File: rtl/watch_multimode.sv
// watch_multimode: time of day, HH/MM setting and stopwatch on 4 BCD digits.
// Define WATCH_BLINK_EN to blink the digits being edited.
module watch_multimode
  import watch_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int HOUR_24      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_one_n,
  input  logic       key_two_n,
  output logic [3:0] Hex_0,
  output logic [3:0] Hex_1,
  output logic [3:0] Hex_2,
  output logic [3:0] Hex_3,
  output logic [1:0] mode
);

  localparam int         PW     = $clog2(CLK_HZ + 1);
  localparam logic       H24    = (HOUR_24 != 0);
  localparam logic [7:0] HH_RST = H24 ? 8'h00 : 8'h12;

  logic p1, s1, l1, p2, s2, l2;

  key_press_detect #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC)
  ) u_key1 (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_one_n),
    .pressed(p1),
    .short_p(s1),
    .long_p (l1)
  );

  key_press_detect #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC)
  ) u_key2 (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_two_n),
    .pressed(p2),
    .short_p(s2),
    .long_p (l2)
  );

  mode_e      mode_q, mode_d;
  view_e      view_q, view_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0] swm_q, swm_d, sws_q, sws_d;
  logic       run_q, run_d;
  logic       sup1_q, sup1_d, sup2_q, sup2_d;
  logic [15:0] hex_q, hex_d;
  logic       k1_short, k2_short, k2_long;
  logic       c1, c2, combo, frozen, tick;

  // combo detection; the partner key stays silent until released
  always_comb begin
    c1       = l1 & ~sup1_q & p2;
    c2       = l2 & ~sup2_q & p1;
    combo    = c1 | c2;
    k1_short = s1 & ~sup1_q;
    k2_short = s2 & ~sup2_q;
    k2_long  = l2 & ~sup2_q & ~p1;
    sup1_d   = p1 & (sup1_q | c2);
    sup2_d   = p2 & (sup2_q | c1);
  end

  // timekeeping, stopwatch and mode FSM next state
  always_comb begin
    mode_d  = mode_q;
    view_d  = view_q;
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    swm_d   = swm_q;
    sws_d   = sws_q;
    run_d   = run_q;
    frozen  = (mode_q == MODE_SET_HH) ||
              (mode_q == MODE_SET_MM);
    tick    = !frozen &&
              (presc_q == PW'(CLK_HZ - 1));
    if (!frozen)
      presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) begin
      ss_d = bcd_inc60(ss_q);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc60(mm_q);
        if (mm_q == 8'h59)
          hh_d = bcd_inc_hour(hh_q, H24);
      end
      if (run_q) begin
        sws_d = bcd_inc60(sws_q);
        if (sws_q == 8'h59)
          swm_d = bcd_inc60(swm_q);
      end
    end
    unique case (mode_q)
      MODE_WATCH: begin
        priority case (1'b1)
          combo:    mode_d = MODE_STOPWATCH;
          k1_short: mode_d = MODE_SET_HH;
          k2_short: view_d = view_e'(~view_q);
          default: ;
        endcase
      end
      MODE_SET_HH: begin
        priority case (1'b1)
          combo:    mode_d = MODE_WATCH;
          k1_short: mode_d = MODE_SET_MM;
          k2_short: hh_d = bcd_inc_hour(hh_q, H24);
          default: ;
        endcase
      end
      MODE_SET_MM: begin
        priority case (1'b1)
          combo:    mode_d = MODE_WATCH;
          k1_short: begin
            mode_d  = MODE_WATCH;
            ss_d    = 8'h00;
            presc_d = '0;
          end
          k2_short: mm_d = bcd_inc60(mm_q);
          default: ;
        endcase
      end
      MODE_STOPWATCH: begin
        priority case (1'b1)
          combo:    mode_d = MODE_WATCH;
          k1_short: mode_d = MODE_WATCH;
          k2_long: begin
            swm_d = 8'h00;
            sws_d = 8'h00;
            run_d = 1'b0;
          end
          k2_short: run_d = ~run_q;
          default: ;
        endcase
      end
      default: mode_d = MODE_WATCH;
    endcase
  end

`ifdef WATCH_BLINK_EN
  localparam int BC = CLK_HZ / 4;
  localparam int BW = $clog2(BC + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  // free-running blink phase
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    blink_d = blink_q;
    if (bcnt_q == BW'(BC - 1)) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end
  end

  // blink registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end
`endif

  // digit mux for the current mode and view
  always_comb begin
    hex_d = {hh_q, mm_q};
    if (mode_q == MODE_STOPWATCH)
      hex_d = {swm_q, sws_q};
    else if (mode_q == MODE_WATCH &&
             view_q == VIEW_MMSS)
      hex_d = {mm_q, ss_q};
`ifdef WATCH_BLINK_EN
    if (blink_q && mode_q == MODE_SET_HH)
      hex_d[15:8] = {DIGIT_BLANK, DIGIT_BLANK};
    if (blink_q && mode_q == MODE_SET_MM)
      hex_d[7:0] = {DIGIT_BLANK, DIGIT_BLANK};
`endif
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_WATCH;
      view_q  <= VIEW_HHMM;
      presc_q <= '0;
      hh_q    <= HH_RST;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      swm_q   <= 8'h00;
      sws_q   <= 8'h00;
      run_q   <= 1'b0;
      sup1_q  <= 1'b0;
      sup2_q  <= 1'b0;
      hex_q   <= {HH_RST, 8'h00};
    end else begin
      mode_q  <= mode_d;
      view_q  <= view_d;
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      swm_q   <= swm_d;
      sws_q   <= sws_d;
      run_q   <= run_d;
      sup1_q  <= sup1_d;
      sup2_q  <= sup2_d;
      hex_q   <= hex_d;
    end
  end

  assign Hex_3 = hex_q[15:12];
  assign Hex_2 = hex_q[11:8];
  assign Hex_1 = hex_q[7:4];
  assign Hex_0 = hex_q[3:0];
  assign mode  = mode_q;

endmodule

// File: doc/watch_multimode.md
# watch_multimode

Parametrised multi-mode digital watch controller: time-of-day keeping (HH:MM:SS), in-place time setting and a stopwatch, driven by two active-low push keys with short and long press detection. Drives four BCD digits to the board's 7-segment decoder stage. It supersedes the fixed two-mode watch controller with configurable clock rate, debounce, long-press threshold and 12/24-hour format.

## Interface
- `CLK_HZ`, 50_000_000: clk frequency; one second equals CLK_HZ cycles.
- `DEBOUNCE_CYC`, 1_000_000: cycles a synchronised key level must be stable before it is accepted.
- `LONG_CYC`, 100_000_000: debounced hold cycles that classify a press as long.
- `HOUR_24`, 1: 1 gives hours 00–23; 0 gives hours 01–12.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `key_one_n` in 1: mode/select key, active low, asynchronous.
- `key_two_n` in 1: action key, active low, asynchronous.
- `Hex_0` out 4: BCD digit, rightmost; 4'hF means blank.
- `Hex_1` out 4: BCD digit.
- `Hex_2` out 4: BCD digit.
- `Hex_3` out 4: BCD digit, leftmost.
- `mode` out 2: current mode (WATCH=0, SET_HH=1, SET_MM=2, STOPWATCH=3).

## Operation
- **Key detector, per key:**
  - 2-flop synchroniser, then debounce counter.
  - SHORT pulse (1 cycle) on debounced release if held < LONG_CYC.
  - LONG pulse (1 cycle) when the hold reaches LONG_CYC. No SHORT follows on release.
- **COMBO event:** LONG of either key while the other key is debounced-pressed. It replaces that LONG. The other key's later release produces no event.
- **Prescaler:** 0..CLK_HZ-1. `tick` fires when it equals CLK_HZ-1.
  - Time advances on `tick`: SS 59→00 carries to MM; MM 59→00 carries to HH.
  - HH wraps 23→00 when HOUR_24=1, or 12→01 when HOUR_24=0.
- **WATCH:**
  - k1 SHORT → SET_HH.
  - k2 SHORT toggles the view between HH:MM and MM:SS.
  - COMBO → STOPWATCH.
- **SET_HH:**
  - Prescaler and seconds are frozen.
  - k2 SHORT increments HH, with the same wrap as timekeeping and no carry.
  - k1 SHORT → SET_MM.
  - Display shows HH:MM.
- **SET_MM:**
  - k2 SHORT increments MM, 59→00, no carry.
  - k1 SHORT → WATCH; SS and the prescaler clear to 0.
- **STOPWATCH:**
  - Display shows the stopwatch MM:SS.
  - k2 SHORT toggles run/stop.
  - k2 LONG clears to 00:00 and stops.
  - k1 SHORT → WATCH; the stopwatch keeps its run state and keeps counting in the background.
  - The stopwatch counts on `tick` when running and wraps 59:59→00:00.
  - Time of day keeps running.
- COMBO in any mode other than WATCH → WATCH. Edits already made are kept; SS is not cleared.
- Events not listed for a mode are ignored.

## Timing
- **Reset values:**
  - mode=0, view HH:MM, stopwatch 00:00 stopped, prescaler 0.
  - Time is 00:00:00 when HOUR_24=1, or 12:00:00 when HOUR_24=0.
  - Hex_3..Hex_0 are 0,0,0,0 when HOUR_24=1, or 1,2,0,0 when HOUR_24=0.
- Reset mid-press clears all detector state. A key already held at reset release is reported as a new press after debounce.
- **Key latency:** press edge to debounced level is 2 + DEBOUNCE_CYC cycles. SHORT is emitted on the debounced-release cycle.
- Event to mode/counter update: 1 cycle. Digit outputs are registered and reflect the update 1 cycle later.
- **tick coinciding with an event:**
  - tick and an edit increment on the same cycle are impossible, because the prescaler is frozen while setting.
  - tick and k1 SHORT leaving SET_MM: the clear wins.
  - tick and k2 LONG clear in STOPWATCH: the clear wins.

## Configuration
- `WATCH_BLINK_EN`: defined.
  - A free-running blink counter toggles a phase bit every CLK_HZ/4 cycles.
  - While the phase is 1, the digits being edited show 4'hF: Hex_3/Hex_2 in SET_HH, Hex_1/Hex_0 in SET_MM.
  - The blink counter resets to phase 0.
- `WATCH_BLINK_EN` undefined: edited digits are always shown, and no blink counter is built.

## Structure
- Package `watch_pkg`:
  - `mode_e` enum (2 bits, encoded as above).
  - `view_e` enum.
  - `DIGIT_BLANK` = 4'hF.
  - BCD increment/wrap helper functions.
- Sub-module `key_press_detect`:
  - Parameters DEBOUNCE_CYC and LONG_CYC.
  - Ports clk, rst, key_n, outputs `pressed`, `short_p`, `long_p`.
  - Instantiated twice.
- Top level: mode FSM, prescaler, BCD time/stopwatch counters, digit mux.

## Test plan
All with CLK_HZ=10, DEBOUNCE_CYC=2, LONG_CYC=20, HOUR_24=1 unless noted.
- Reset then 600 cycles idle → view MM:SS reads 01:00; HH:MM reads 00:01.
- k1 held 5 cycles → SET_HH; k2 short ×25 → HH=01, which checks the 23→00 wrap; k1 short ×2 → WATCH with SS=00.
- Preload 23:59:59, run 10 cycles → 00:00:00. With HOUR_24=0, preload 12:59:59 → 01:00:00.
- Both keys held 25 cycles → mode=3, no SHORT on release; k2 short starts counting; 600 cycles → 01:00; k2 long → 00:00, stopped.
- k2 glitch of 1 cycle → no event. Assert rst mid-press → outputs return to reset values the next cycle.
- With WATCH_BLINK_EN in SET_MM → Hex_1/Hex_0 alternate between the value and 4'hF every 2 cycles; Hex_3/Hex_2 are steady.
